// File: rtl/ce_pilot_buffer.sv
// ce_pilot_buffer
// Double-buffered capture of four signed LS pilot estimates (one I or Q
// component). The write side fills one bank while the interpolator reads the
// other. Each bank is released when interp_done arrives.
module ce_pilot_buffer #(
  parameter int IN_WIDTH = 17
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic signed [IN_WIDTH-1:0] est_in,
  input  logic                       est_valid,
  output logic                       est_ready,
  input  logic                       interp_done,
  output logic signed [IN_WIDTH-1:0] E1,
  output logic signed [IN_WIDTH-1:0] E2,
  output logic signed [IN_WIDTH-1:0] E3,
  output logic signed [IN_WIDTH-1:0] E4,
  output logic                       e_valid,
  output logic                       ovf
);

  logic signed [IN_WIDTH-1:0] bank0 [4];
  logic signed [IN_WIDTH-1:0] bank1 [4];
  logic [1:0] full;
  logic       wr_bank;
  logic [1:0] wr_cnt;
  logic       rd_bank;
  logic       accept;
  logic       release_rd;
  logic       drop;

  // Handshake decode. The bank under write is never full, so completing it and
  // releasing the read bank in the same cycle always touch different banks.
  always_comb begin
    est_ready  = ~full[wr_bank];
    e_valid    = full[rd_bank];
    accept     = est_valid & est_ready;
    drop       = est_valid & ~est_ready;
    release_rd = interp_done & e_valid;
  end

  // Sample storage. flush leaves the contents alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (!flush && accept) begin
      if (wr_bank == 1'b0) bank0[wr_cnt] <= est_in;
      else                 bank1[wr_cnt] <= est_in;
    end
  end

  // Write pointer, read pointer, bank full flags and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      wr_cnt  <= 2'd0;
      rd_bank <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        wr_cnt <= wr_cnt + 2'd1;
        if (wr_cnt == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (release_rd) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (drop) ovf <= 1'b1;
    end
  end

  // Read operands are taken straight from the registers of the read bank.
  always_comb begin
    if (rd_bank == 1'b0) begin
      E1 = bank0[0];
      E2 = bank0[1];
      E3 = bank0[2];
      E4 = bank0[3];
    end else begin
      E1 = bank1[0];
      E2 = bank1[1];
      E3 = bank1[2];
      E4 = bank1[3];
    end
  end

endmodule

// File: tb/tb_ce_pilot_buffer.sv
// tb_ce_pilot_buffer
// Directed vectors for ce_pilot_buffer. Each record describes the inputs for
// one clock edge and the outputs expected just after that edge.
module tb_ce_pilot_buffer;

  localparam int W = 17;

  logic                clk = 1'b0;
  logic                rst_n, flush, est_valid, interp_done;
  logic signed [W-1:0] est_in;
  logic                est_ready, e_valid, ovf;
  logic signed [W-1:0] E1, E2, E3, E4;

  int checks = 0;
  int errors = 0;

  ce_pilot_buffer #(.IN_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .est_in(est_in),
    .est_valid(est_valid), .est_ready(est_ready), .interp_done(interp_done),
    .E1(E1), .E2(E2), .E3(E3), .E4(E4), .e_valid(e_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rn, fl, v;
    int   d;
    logic dn;
    logic x_rdy, x_ev, x_ovf;
    int   x1, x2, x3, x4;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rn, fl, v, input int d, input logic dn,
                     input logic x_rdy, x_ev, x_ovf,
                     input int x1, x2, x3, x4);
    vec_t t;
    t.rn = rn; t.fl = fl; t.v = v; t.d = d; t.dn = dn;
    t.x_rdy = x_rdy; t.x_ev = x_ev; t.x_ovf = x_ovf;
    t.x1 = x1; t.x2 = x2; t.x3 = x3; t.x4 = x4;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t t);
    chk("est_ready", idx, {31'd0, est_ready}, {31'd0, t.x_rdy});
    chk("e_valid",   idx, {31'd0, e_valid},   {31'd0, t.x_ev});
    chk("ovf",       idx, {31'd0, ovf},       {31'd0, t.x_ovf});
    chk("E1", idx, 32'(E1), t.x1);
    chk("E2", idx, 32'(E2), t.x2);
    chk("E3", idx, 32'(E3), t.x3);
    chk("E4", idx, 32'(E4), t.x4);
  endtask

  task automatic drive(input logic rn, fl, v, input int d, input logic dn);
    rst_n = rn; flush = fl; est_valid = v; est_in = W'(d); interp_done = dn;
  endtask

  initial begin
    int n;
    vec_t h;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);

    //  rn fl v  data   dn   rdy ev ovf  E1   E2    E3   E4
    // reset with junk inputs
    add(0, 1, 1, 5,      1,   1, 0, 0,   0,   0,    0,   0);
    add(0, 0, 1, 7,      1,   1, 0, 0,   0,   0,    0,   0);
    // single set into bank 0
    add(1, 0, 1, 100,    0,   1, 0, 0,   100, 0,    0,   0);
    add(1, 0, 1, -200,   0,   1, 0, 0,   100, -200, 0,   0);
    add(1, 0, 1, 300,    0,   1, 0, 0,   100, -200, 300, 0);
    add(1, 0, 1, -65536, 0,   1, 1, 0,   100, -200, 300, -65536);
    add(1, 0, 0, 0,      0,   1, 1, 0,   100, -200, 300, -65536);
    add(1, 0, 0, 0,      1,   1, 0, 0,   0,   0,    0,   0);
    // interp_done with nothing valid is ignored (read bank stays 1)
    add(1, 0, 0, 0,      1,   1, 0, 0,   0,   0,    0,   0);
    // double buffering: 1..4 into bank 1, 5..8 into bank 0
    add(1, 0, 1, 1,      0,   1, 0, 0,   1,   0,    0,   0);
    add(1, 0, 1, 2,      0,   1, 0, 0,   1,   2,    0,   0);
    add(1, 0, 1, 3,      0,   1, 0, 0,   1,   2,    3,   0);
    add(1, 0, 1, 4,      0,   1, 1, 0,   1,   2,    3,   4);
    add(1, 0, 1, 5,      0,   1, 1, 0,   1,   2,    3,   4);
    add(1, 0, 1, 6,      0,   1, 1, 0,   1,   2,    3,   4);
    add(1, 0, 1, 7,      0,   1, 1, 0,   1,   2,    3,   4);
    add(1, 0, 1, 8,      0,   0, 1, 0,   1,   2,    3,   4);
    // overflow: 77 dropped
    add(1, 0, 1, 77,     0,   0, 1, 1,   1,   2,    3,   4);
    add(1, 0, 0, 0,      1,   1, 1, 1,   5,   6,    7,   8);
    add(1, 0, 0, 0,      1,   1, 0, 1,   1,   2,    3,   4);
    // flush clears pointers and ovf, keeps data
    add(1, 1, 0, 0,      0,   1, 0, 0,   5,   6,    7,   8);
    // simultaneous completion of bank 1 and release of bank 0
    add(1, 0, 1, 11,     0,   1, 0, 0,   11,  6,    7,   8);
    add(1, 0, 1, 12,     0,   1, 0, 0,   11,  12,   7,   8);
    add(1, 0, 1, 13,     0,   1, 0, 0,   11,  12,   13,  8);
    add(1, 0, 1, 14,     0,   1, 1, 0,   11,  12,   13,  14);
    add(1, 0, 1, 21,     0,   1, 1, 0,   11,  12,   13,  14);
    add(1, 0, 1, 22,     0,   1, 1, 0,   11,  12,   13,  14);
    add(1, 0, 1, 23,     0,   1, 1, 0,   11,  12,   13,  14);
    add(1, 0, 1, 24,     1,   1, 1, 0,   21,  22,   23,  24);
    add(1, 0, 0, 0,      1,   1, 0, 0,   11,  12,   13,  14);
    // mid-fill flush, overriding a same-cycle accept and interp_done
    add(1, 0, 1, 31,     0,   1, 0, 0,   31,  12,   13,  14);
    add(1, 0, 1, 32,     0,   1, 0, 0,   31,  32,   13,  14);
    add(1, 1, 1, 99,     1,   1, 0, 0,   31,  32,   13,  14);
    add(1, 0, 1, 9,      0,   1, 0, 0,   9,   32,   13,  14);
    add(1, 0, 1, 10,     0,   1, 0, 0,   9,   10,   13,  14);
    add(1, 0, 1, 11,     0,   1, 0, 0,   9,   10,   11,  14);
    add(1, 0, 1, 12,     0,   1, 1, 0,   9,   10,   11,  12);
    add(1, 0, 0, 0,      1,   1, 0, 0,   21,  22,   23,  24);
    // mid-fill reset into bank 1
    add(1, 0, 1, 41,     0,   1, 0, 0,   41,  22,   23,  24);
    add(1, 0, 1, 42,     0,   1, 0, 0,   41,  42,   23,  24);
    add(0, 1, 1, 55,     1,   1, 0, 0,   0,   0,    0,   0);
    add(1, 0, 1, 9,      0,   1, 0, 0,   9,   0,    0,   0);
    add(1, 0, 1, 10,     0,   1, 0, 0,   9,   10,   0,   0);
    add(1, 0, 1, 11,     0,   1, 0, 0,   9,   10,   11,  0);
    add(1, 0, 1, 12,     0,   1, 1, 0,   9,   10,   11,  12);

    foreach (vq[i]) begin
      drive(vq[i].rn, vq[i].fl, vq[i].v, vq[i].d, vq[i].dn);
      @(posedge clk);
      #1;
      check_all(i, vq[i]);
    end

    // Hand sequence: release bank 0, fill bank 1 with gaps, e_valid must rise
    // only after the fourth accept and within a bounded wait.
    drive(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("release_ev", 100, {31'd0, e_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, -1000 * (k + 1), 0);
      @(posedge clk); #1;
      if (k < 3) chk("early_ev", 101 + k, {31'd0, e_valid}, 32'd0);
      drive(1, 0, 0, 0, 0);
      if (k < 3) begin
        @(posedge clk); #1;
      end
    end
    n = 0;
    while (e_valid !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ev_latency", 105, n, 0);
    h.rn = 1; h.fl = 0; h.v = 0; h.d = 0; h.dn = 0;
    h.x_rdy = 1; h.x_ev = 1; h.x_ovf = 0;
    h.x1 = -1000; h.x2 = -2000; h.x3 = -3000; h.x4 = -4000;
    check_all(106, h);

    // Hand sequence: a pulse with both banks empty later leaves ovf clear and
    // holding est_valid past a full condition sets ovf sticky.
    drive(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("empty_ev", 107, {31'd0, e_valid}, 32'd0);
    drive(1, 0, 1, 3, 0);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    chk("ovf_sticky", 108, {31'd0, ovf}, 32'd1);
    chk("ovf_rdy", 109, {31'd0, est_ready}, 32'd0);
    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_hold", 110, {31'd0, ovf}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ce_pilot_buffer.md
# ce_pilot_buffer

Double-buffered capture stage directly upstream of the channel-estimation interpolation datapath. It collects the per-slot stream of four signed LS pilot estimates, one component (real or imaginary) per instance, and holds them stable as parallel operands E1..E4 for the interpolation adders and operand muxes. It releases each set when the interpolator signals completion. One instance is used per I/Q component.

## Interface
Parameters:
- IN_WIDTH, 17, width of each signed pilot estimate and of E1..E4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- flush  in  1  synchronous clear of counters/flags (data registers untouched).
- est_in  in  IN_WIDTH  signed pilot estimate, in pilot order E1, E2, E3, E4.
- est_valid  in  1  est_in valid this cycle.
- est_ready  out  1  buffer can accept est_in this cycle.
- interp_done  in  1  single-cycle pulse: interpolator finished with current E1..E4.
- E1, E2, E3, E4  out  IN_WIDTH each  signed held estimates of the current read bank.
- e_valid  out  1  E1..E4 hold a complete set.
- ovf  out  1  sticky flag: est_valid seen while est_ready low.

## Operation
- Storage: two banks (0, 1), each with four IN_WIDTH registers and a full flag full[b].
- Write side:
  - wr_bank (1 bit) and wr_cnt (2 bits) track the next slot.
  - est_ready = ~full[wr_bank].
  - Accept when est_valid & est_ready: store est_in in bank[wr_bank][wr_cnt], then wr_cnt++.
  - On accepting with wr_cnt==3: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side:
  - rd_bank (1 bit). e_valid = full[rd_bank].
  - E1..E4 = bank[rd_bank][0..3], driven combinationally from registers with no arithmetic and no width change.
  - When interp_done & e_valid: clear full[rd_bank] and toggle rd_bank.
  - interp_done with e_valid low is ignored.
- Simultaneous events:
  - A bank completing on the write side and the other bank being released on the read side in the same cycle are both applied.
  - The bank being written is never full, so it cannot be the one being released.
- Dropped input: est_valid & ~est_ready drops the sample and sets ovf. ovf clears only on rst_n low or flush.
- flush (rst_n high):
  - Clears full[1:0], wr_cnt, wr_bank, rd_bank and ovf.
  - Bank contents are kept.
  - Takes priority over a same-cycle accept or interp_done; both are ignored that cycle.
- Reset (rst_n low at an edge):
  - All bank registers cleared to 0, so E1..E4 = 0.
  - e_valid=0, est_ready=1, ovf=0.
  - wr_cnt, wr_bank and rd_bank cleared to 0.
  - Reset overrides flush and all other inputs, including mid-fill.

## Timing
- All state updates on the rising edge of clk. No combinational path from est_valid or interp_done to any output.
- Latency: when the 4th sample is accepted at edge k into the bank equal to rd_bank, e_valid is high in the cycle after edge k.
- E1..E4 are stable for as long as e_valid is high and change only on the edge that consumes interp_done.
- Throughput: one sample per cycle sustained, provided interp_done arrives within 4 cycles of e_valid rising.
- Backpressure: est_ready drops the cycle after the second bank fills while the first is unreleased. It returns the cycle after the interp_done edge.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with random inputs -> E1..E4=0, e_valid=0, est_ready=1, ovf=0.
- Single set: stream 100, -200, 300, -65536 on consecutive cycles -> e_valid high one cycle after 4th accept; E1=100, E2=-200, E3=300, E4=-65536 (IN_WIDTH=17); interp_done pulse -> e_valid low next cycle.
- Double buffering: stream 8 samples 1..8 back-to-back without interp_done -> est_ready low after 8th accept, E1..E4=1..4. Pulse interp_done -> E1..E4=5..8 next cycle and est_ready high.
- Overflow: with both banks full, assert est_valid with est_in=77 -> sample dropped, ovf=1. After releases, no bank contains 77.
- Simultaneous: bank 0 full and valid, 4th sample into bank 1 accepted in the same cycle as interp_done -> next cycle e_valid=1 and E1..E4 show bank 1 data.
- Mid-fill reset/flush: accept 2 samples, pulse flush -> wr_cnt restarts. The next 4 samples 9..12 give E1..E4=9..12. Repeat with rst_n low at the same point -> identical outcome with zeroed banks before refill.
